// File: rtl/spi_ctrl.sv
// spi_ctrl: SPI/QSPI initiator for the SPI RAM peripheral (03h/02h/6Bh/32h).
// SCK runs at clk/2. Every SCK bit is two clk cycles: phase L (SCK low,
// outputs change) and phase H (SCK high, input lanes sampled on entry).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | deselected, waiting for start
// S_CMD   | opcode + 24-bit address shifted out on D0, MSB first
// S_DUMMY | quad-read turnaround, lanes released, nothing sampled
// S_DATA  | data bytes moving (single lane or quad)
// S_END   | deselected, busy held for the CS idle gap
module spi_ctrl #(
  parameter int LEN_BITS     = 8,
  parameter int DUMMY_CYCLES = 2,
  parameter int CS_IDLE      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cmd_write,
  input  logic                cmd_quad,
  input  logic [23:0]         addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic [7:0]          wr_data,
  output logic                wr_taken,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                done,
  output logic                spi_select,
  output logic                spi_clk_out,
  output logic [3:0]          spi_d_out,
  output logic [3:0]          spi_d_oe,
  input  logic [3:0]          spi_d_in
);

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_QREAD  = 8'h6B;
  localparam logic [7:0] OP_QWRITE = 8'h32;

  localparam int DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
  localparam int IW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DUMMY,
    S_DATA,
    S_END
  } state_t;

  state_t              state_q;
  logic                phase_q;      // 0 = phase L, 1 = phase H
  logic                sck_q;
  logic                sel_q;
  logic [3:0]          dout_q;
  logic [3:0]          oe_q;
  logic [30:0]         cmd_sh_q;     // command bits still to be sent after D0
  logic [4:0]          bit_cnt_q;    // remaining bits/nibbles in current unit
  logic [DW-1:0]       dummy_cnt_q;
  logic [IW-1:0]       idle_cnt_q;
  logic [LEN_BITS-1:0] byte_cnt_q;
  logic                write_q;
  logic                quad_q;
  logic [7:0]          wr_hold_q;    // first write byte, captured with start
  logic [7:0]          wsh_q;        // write shifter, remaining bits
  logic [6:0]          rsh_q;        // read shifter, bits received so far
  logic [7:0]          rd_data_q;
  logic                rd_valid_q;
  logic                wr_taken_q;
  logic                busy_q;
  logic                done_q;

  logic [7:0]          opcode_d;
  logic [7:0]          wr_src_d;
  logic [7:0]          rd_next_d;
  logic [3:0]          ld_dout_d;
  logic [3:0]          ld_oe_d;
  logic [7:0]          ld_wsh_d;
  logic [4:0]          ld_bits_d;

  // Opcode selection, next read byte and the per-byte shifter load values.
  always_comb begin
    opcode_d = OP_READ;
    case ({cmd_quad, cmd_write})
      2'b00:   opcode_d = OP_READ;
      2'b01:   opcode_d = OP_WRITE;
      2'b10:   opcode_d = OP_QREAD;
      default: opcode_d = OP_QWRITE;
    endcase

    rd_next_d = quad_q ? {rsh_q[3:0], spi_d_in} : {rsh_q, spi_d_in[1]};

    // The first data byte comes from the copy taken with start; later bytes
    // are taken live from the host at each byte boundary.
    wr_src_d  = (state_q == S_CMD) ? wr_hold_q : wr_data;
    ld_dout_d = 4'b0000;
    ld_oe_d   = 4'b0000;
    ld_wsh_d  = 8'h00;
    ld_bits_d = quad_q ? 5'd1 : 5'd7;
    if (write_q) begin
      if (quad_q) begin
        ld_dout_d = wr_src_d[7:4];
        ld_wsh_d  = {wr_src_d[3:0], 4'h0};
        ld_oe_d   = 4'b1111;
      end else begin
        ld_dout_d = {3'b000, wr_src_d[7]};
        ld_wsh_d  = {wr_src_d[6:0], 1'b0};
        ld_oe_d   = 4'b0001;
      end
    end
  end

  // Transaction FSM; every pin-facing output is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      sck_q       <= 1'b0;
      sel_q       <= 1'b1;
      dout_q      <= 4'b0000;
      oe_q        <= 4'b0000;
      cmd_sh_q    <= '0;
      bit_cnt_q   <= 5'd0;
      dummy_cnt_q <= '0;
      idle_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      write_q     <= 1'b0;
      quad_q      <= 1'b0;
      wr_hold_q   <= 8'h00;
      wsh_q       <= 8'h00;
      rsh_q       <= 7'h00;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      wr_taken_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_taken_q <= 1'b0;
      done_q     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start && !busy_q) begin
            write_q    <= cmd_write;
            quad_q     <= cmd_quad;
            byte_cnt_q <= len;
            wr_hold_q  <= wr_data;
            cmd_sh_q   <= {opcode_d[6:0], addr};
            dout_q     <= {3'b000, opcode_d[7]};
            oe_q       <= 4'b0001;
            sel_q      <= 1'b0;
            sck_q      <= 1'b0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= 5'd31;
            busy_q     <= 1'b1;
            state_q    <= S_CMD;
          end
        end

        S_CMD: begin
          if (!phase_q) begin
            sck_q   <= 1'b1;
            phase_q <= 1'b1;
          end else begin
            sck_q   <= 1'b0;
            phase_q <= 1'b0;
            if (bit_cnt_q != 5'd0) begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              dout_q    <= {3'b000, cmd_sh_q[30]};
              cmd_sh_q  <= {cmd_sh_q[29:0], 1'b0};
            end else if (byte_cnt_q == '0) begin
              state_q    <= S_END;
              sel_q      <= 1'b1;
              oe_q       <= 4'b0000;
              dout_q     <= 4'b0000;
              done_q     <= 1'b1;
              idle_cnt_q <= IW'(CS_IDLE - 1);
            end else if (quad_q && !write_q) begin
              state_q     <= S_DUMMY;
              oe_q        <= 4'b0000;
              dout_q      <= 4'b0000;
              dummy_cnt_q <= DW'(DUMMY_CYCLES - 1);
            end else begin
              state_q    <= S_DATA;
              dout_q     <= ld_dout_d;
              oe_q       <= ld_oe_d;
              wsh_q      <= ld_wsh_d;
              bit_cnt_q  <= ld_bits_d;
              wr_taken_q <= write_q;
            end
          end
        end

        S_DUMMY: begin
          if (!phase_q) begin
            sck_q   <= 1'b1;
            phase_q <= 1'b1;
          end else begin
            sck_q   <= 1'b0;
            phase_q <= 1'b0;
            if (dummy_cnt_q == '0) begin
              state_q   <= S_DATA;
              bit_cnt_q <= 5'd1;
            end else begin
              dummy_cnt_q <= dummy_cnt_q - DW'(1);
            end
          end
        end

        S_DATA: begin
          if (!phase_q) begin
            sck_q   <= 1'b1;
            phase_q <= 1'b1;
            if (!write_q) begin
              rsh_q <= rd_next_d[6:0];
              if (bit_cnt_q == 5'd0) begin
                rd_data_q  <= rd_next_d;
                rd_valid_q <= 1'b1;
              end
            end
          end else begin
            sck_q   <= 1'b0;
            phase_q <= 1'b0;
            if (bit_cnt_q != 5'd0) begin
              bit_cnt_q <= bit_cnt_q - 5'd1;
              if (write_q) begin
                if (quad_q) begin
                  dout_q <= wsh_q[7:4];
                  wsh_q  <= {wsh_q[3:0], 4'h0};
                end else begin
                  dout_q <= {3'b000, wsh_q[7]};
                  wsh_q  <= {wsh_q[6:0], 1'b0};
                end
              end
            end else if (byte_cnt_q == LEN_BITS'(1)) begin
              byte_cnt_q <= '0;
              state_q    <= S_END;
              sel_q      <= 1'b1;
              oe_q       <= 4'b0000;
              dout_q     <= 4'b0000;
              done_q     <= 1'b1;
              idle_cnt_q <= IW'(CS_IDLE - 1);
            end else begin
              byte_cnt_q <= byte_cnt_q - LEN_BITS'(1);
              dout_q     <= ld_dout_d;
              oe_q       <= ld_oe_d;
              wsh_q      <= ld_wsh_d;
              bit_cnt_q  <= ld_bits_d;
              wr_taken_q <= write_q;
            end
          end
        end

        S_END: begin
          if (idle_cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            idle_cnt_q <= idle_cnt_q - IW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          sel_q   <= 1'b1;
          sck_q   <= 1'b0;
          oe_q    <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_taken    = wr_taken_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign spi_select  = sel_q;
  assign spi_clk_out = sck_q;
  assign spi_d_out   = dout_q;
  assign spi_d_oe    = oe_q;

endmodule

// File: tb/tb_spi_ctrl.sv
// Directed bench for spi_ctrl with a small SPI RAM pin model.
module tb_spi_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cmd_write;
  logic       cmd_quad;
  logic [23:0] addr;
  logic [7:0] len;
  logic [7:0] wr_data;
  logic       wr_taken;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       spi_select;
  logic       spi_clk_out;
  logic [3:0] spi_d_out;
  logic [3:0] spi_d_oe;
  logic [3:0] spi_d_in;

  spi_ctrl #(.LEN_BITS(8), .DUMMY_CYCLES(2), .CS_IDLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_write(cmd_write),
    .cmd_quad(cmd_quad), .addr(addr), .len(len), .wr_data(wr_data),
    .wr_taken(wr_taken), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .spi_select(spi_select),
    .spi_clk_out(spi_clk_out), .spi_d_out(spi_d_out), .spi_d_oe(spi_d_oe),
    .spi_d_in(spi_d_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peripheral model state
  logic        quad_rd_mode = 1'b0;
  logic [7:0]  rd_img [0:7];
  logic [7:0]  wr_img [0:7];
  int          wr_idx = 0;
  int          rise_cnt = 0;
  int          sck_total = 0;
  int          rdv_cnt = 0;
  int          wrt_cnt = 0;
  int          done_cnt = 0;
  logic        prev_sck = 1'b0;
  logic [31:0] cmd_word = 32'h0;
  logic [3:0]  dout_log [0:63];
  logic [3:0]  oe_log [0:63];
  logic [7:0]  rd_q [$];

  function automatic logic [3:0] din_for(input int n);
    logic [7:0] b;
    int k;
    din_for = 4'b0000;
    if (!quad_rd_mode && n >= 32) begin
      k = n - 32;
      b = rd_img[(k / 8) % 8];
      din_for = {2'b00, b[7 - (k % 8)], 1'b0};
    end else if (quad_rd_mode && n >= 34) begin
      k = n - 34;
      b = rd_img[(k / 2) % 8];
      din_for = (k % 2 == 0) ? b[7:4] : b[3:0];
    end
  endfunction

  // Pin-level monitor and responder, evaluated away from the active edge.
  always @(negedge clk) begin
    if (spi_select) begin
      rise_cnt = 0;
    end else if (spi_clk_out && !prev_sck) begin
      if (rise_cnt < 32) cmd_word = {cmd_word[30:0], spi_d_out[0]};
      if (rise_cnt < 64) begin
        dout_log[rise_cnt] = spi_d_out;
        oe_log[rise_cnt]   = spi_d_oe;
      end
      rise_cnt++;
      sck_total++;
    end
    if (!spi_clk_out) spi_d_in = din_for(rise_cnt);
    if (rd_valid) begin
      rdv_cnt++;
      rd_q.push_back(rd_data);
    end
    if (wr_taken) begin
      wrt_cnt++;
      if (wr_idx < 7) wr_idx++;
      wr_data = wr_img[wr_idx];
    end
    if (done) done_cnt++;
    prev_sck = spi_clk_out;
  end

  task automatic run_txn(input logic w, input logic q, input logic [23:0] a,
                         input logic [7:0] l, input int extra_at);
    bit ok;
    ok = 1'b0;
    rd_q.delete();
    rdv_cnt = 0; wrt_cnt = 0; done_cnt = 0; sck_total = 0;
    cmd_word = 32'h0;
    quad_rd_mode = q && !w;
    wr_idx = 0;
    @(negedge clk);
    wr_data = wr_img[0];
    cmd_write = w; cmd_quad = q; addr = a; len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == extra_at) begin
        start = 1'b1; cmd_write = 1'b1; addr = 24'hFFFFFF; len = 8'd5;
      end else begin
        start = 1'b0;
      end
      if (done_cnt > 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!ok) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] b;

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_write = 1'b0; cmd_quad = 1'b0;
    addr = 24'h0; len = 8'h0; wr_data = 8'h0; spi_d_in = 4'h0;
    for (int i = 0; i < 8; i++) begin
      rd_img[i] = 8'h00;
      wr_img[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_select", {31'd0, spi_select}, 32'd1);
    chk("rst_sck", {31'd0, spi_clk_out}, 32'd0);
    chk("rst_dout_oe", {24'd0, spi_d_out, spi_d_oe}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, rd_valid, wr_taken}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    rst_n = 1'b1;

    // 1: single read
    rd_img[0] = 8'hA5;
    run_txn(1'b0, 1'b0, 24'h000010, 8'd1, -1);
    chk("t1_cmd", cmd_word, 32'h03000010);
    chk("t1_sck", sck_total, 32'd40);
    chk("t1_oe_cmd", {28'd0, oe_log[0]}, 32'h1);
    chk("t1_oe_data", {28'd0, oe_log[32]}, 32'h0);
    chk("t1_rdv", rdv_cnt, 32'd1);
    chk("t1_rd0", (rd_q.size() > 0) ? {24'd0, rd_q[0]} : 32'hDEAD, 32'hA5);
    chk("t1_done", done_cnt, 32'd1);

    // 2: single write
    wr_img[0] = 8'h3C; wr_img[1] = 8'hC3;
    run_txn(1'b1, 1'b0, 24'h000003, 8'd2, -1);
    chk("t2_cmd", cmd_word, 32'h02000003);
    chk("t2_sck", sck_total, 32'd48);
    chk("t2_wrt", wrt_cnt, 32'd2);
    for (int by = 0; by < 2; by++) begin
      for (int i = 0; i < 8; i++) b[7 - i] = dout_log[32 + by * 8 + i][0];
      chk($sformatf("t2_byte%0d", by), {24'd0, b}, (by == 0) ? 32'h3C : 32'hC3);
    end
    chk("t2_oe_data", {28'd0, oe_log[40]}, 32'h1);

    // 3: quad read
    rd_img[0] = 8'h12; rd_img[1] = 8'h34; rd_img[2] = 8'h56; rd_img[3] = 8'h78;
    run_txn(1'b0, 1'b1, 24'h000100, 8'd4, -1);
    chk("t3_cmd", cmd_word, 32'h6B000100);
    chk("t3_sck", sck_total, 32'd42);
    chk("t3_oe_cmd", {28'd0, oe_log[31]}, 32'h1);
    chk("t3_oe_dummy", {24'd0, oe_log[32], oe_log[33]}, 32'h0);
    chk("t3_rdv", rdv_cnt, 32'd4);
    chk("t3_bytes", (rd_q.size() == 4) ? {rd_q[0], rd_q[1], rd_q[2], rd_q[3]} : 32'hDEAD,
        32'h12345678);

    // 4: quad write
    wr_img[0] = 8'hDE; wr_img[1] = 8'hAD; wr_img[2] = 8'hBE;
    run_txn(1'b1, 1'b1, 24'h000000, 8'd3, -1);
    chk("t4_cmd", cmd_word, 32'h32000000);
    chk("t4_sck", sck_total, 32'd38);
    chk("t4_wrt", wrt_cnt, 32'd3);
    chk("t4_nibbles", {8'd0, dout_log[32], dout_log[33], dout_log[34], dout_log[35],
        dout_log[36], dout_log[37]}, 32'h00DEADBE);
    chk("t4_oe", {16'd0, oe_log[32], oe_log[33], oe_log[36], oe_log[37]}, 32'hFFFF);

    // 5: len=0, with a start pulse while busy
    run_txn(1'b0, 1'b0, 24'h000010, 8'd0, 10);
    chk("t5_cmd", cmd_word, 32'h03000010);
    chk("t5_sck", sck_total, 32'd32);
    chk("t5_rdv_wrt", rdv_cnt + wrt_cnt, 32'd0);
    chk("t5_done", done_cnt, 32'd1);
    repeat (4) @(negedge clk);
    chk("t5_ignored_sel", {31'd0, spi_select}, 32'd1);
    chk("t5_ignored_busy", {31'd0, busy}, 32'd0);

    // 6: reset mid quad read, then a fresh transfer
    quad_rd_mode = 1'b1;
    @(negedge clk);
    cmd_write = 1'b0; cmd_quad = 1'b1; addr = 24'h000100; len = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_active", {31'd0, spi_select}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_sel", {31'd0, spi_select}, 32'd1);
    chk("t6_oe", {28'd0, spi_d_oe}, 32'h0);
    chk("t6_sck_busy", {30'd0, spi_clk_out, busy}, 32'd0);
    rst_n = 1'b1;
    rd_img[0] = 8'h5A;
    run_txn(1'b0, 1'b0, 24'h000010, 8'd1, -1);
    chk("t6_after_rd", (rd_q.size() > 0) ? {24'd0, rd_q[0]} : 32'hDEAD, 32'h5A);
    chk("t6_after_sck", sck_total, 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
